// File: rtl/rgs_prng_bank.sv
// Bank of independent Galois LFSR channels feeding one round-robin output register.
// Free-run steps every channel each cycle; on-demand steps only the channel just captured.
module rgs_prng_bank #(
    parameter int              WIDTH        = 16,
    parameter int              CHANNELS     = 2,
    parameter logic [WIDTH-1:0] POLY         = 16'hB400,
    parameter logic [WIDTH-1:0] DEFAULT_SEED = 16'hACE1,
    localparam int             CW           = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             seed_we,
    input  logic [CW-1:0]    seed_ch,
    input  logic [WIDTH-1:0] seed_data,
    input  logic             rnd_ready,
    output logic             rnd_valid,
    output logic [WIDTH-1:0] rnd_data,
    output logic [CW-1:0]    rnd_ch,
    output logic             zero_seed
);

    localparam logic [1:0] MODE_FREE   = 2'b01;
    localparam logic [1:0] MODE_DEMAND = 2'b10;

    logic                      free_run;
    logic                      on_demand;
    logic                      load;
    logic [CHANNELS*WIDTH-1:0] state_flat;
    logic [CHANNELS-1:0]       seed_hit_vec;
    logic [WIDTH-1:0]          sel_word;

    logic             rnd_valid_q, rnd_valid_d;
    logic [WIDTH-1:0] rnd_data_q, rnd_data_d;
    logic [CW-1:0]    rnd_ch_q, rnd_ch_d;
    logic [CW-1:0]    ptr_q, ptr_d;
    logic             zero_seed_q, zero_seed_d;

    assign free_run  = en & (mode == MODE_FREE);
    assign on_demand = (mode == MODE_DEMAND);
    assign load      = en & ((mode == MODE_FREE) | (mode == MODE_DEMAND))
                     & (~rnd_valid_q | rnd_ready);

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
            logic [WIDTH-1:0] s_q, s_d;
            logic             seed_hit;
            logic             step;

            // An out-of-range seed_ch matches no channel, so such writes vanish here.
            assign seed_hit = seed_we & (seed_ch == CW'(gi));
            assign step     = free_run | (load & on_demand & (ptr_q == CW'(gi)));

            always_comb begin
                s_d = s_q;
                if (seed_hit) begin
                    s_d = (seed_data == '0) ? (DEFAULT_SEED + WIDTH'(gi)) : seed_data;
                end else if (step) begin
                    s_d = s_q[0] ? ((s_q >> 1) ^ POLY) : (s_q >> 1);
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s_q <= DEFAULT_SEED + WIDTH'(gi);
                end else begin
                    s_q <= s_d;
                end
            end

            assign state_flat[gi*WIDTH +: WIDTH] = s_q;
            assign seed_hit_vec[gi]              = seed_hit;
        end
    endgenerate

    // Captured word is the pre-step, pre-seed value of the selected channel.
    always_comb begin
        sel_word = state_flat[WIDTH-1:0];
        for (int i = 0; i < CHANNELS; i++) begin
            if (ptr_q == CW'(i)) begin
                sel_word = state_flat[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        rnd_valid_d = rnd_valid_q;
        rnd_data_d  = rnd_data_q;
        rnd_ch_d    = rnd_ch_q;
        ptr_d       = ptr_q;
        zero_seed_d = (|seed_hit_vec) & (seed_data == '0);
        if (load) begin
            rnd_valid_d = 1'b1;
            rnd_data_d  = sel_word;
            rnd_ch_d    = ptr_q;
            ptr_d       = (ptr_q == CW'(CHANNELS - 1)) ? '0 : ptr_q + CW'(1);
        end else if (rnd_valid_q & rnd_ready) begin
            rnd_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rnd_valid_q <= 1'b0;
            rnd_data_q  <= '0;
            rnd_ch_q    <= '0;
            ptr_q       <= '0;
            zero_seed_q <= 1'b0;
        end else begin
            rnd_valid_q <= rnd_valid_d;
            rnd_data_q  <= rnd_data_d;
            rnd_ch_q    <= rnd_ch_d;
            ptr_q       <= ptr_d;
            zero_seed_q <= zero_seed_d;
        end
    end

    assign rnd_valid = rnd_valid_q;
    assign rnd_data  = rnd_data_q;
    assign rnd_ch    = rnd_ch_q;
    assign zero_seed = zero_seed_q;

endmodule

// File: tb/tb_rgs_prng_bank.sv
// Directed bench for rgs_prng_bank: default 2-channel instance plus a 3-channel instance
// used for out-of-range seed writes and the non-power-of-two pointer wrap.
module tb_rgs_prng_bank;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en, seed_we, rnd_ready;
    logic [1:0]  mode;
    logic [0:0]  seed_ch;
    logic [15:0] seed_data;
    logic        rnd_valid, zero_seed;
    logic [15:0] rnd_data;
    logic [0:0]  rnd_ch;

    logic        en3, seed_we3, rnd_ready3;
    logic [1:0]  mode3;
    logic [1:0]  seed_ch3;
    logic [15:0] seed_data3;
    logic        rnd_valid3, zero_seed3;
    logic [15:0] rnd_data3;
    logic [1:0]  rnd_ch3;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    rgs_prng_bank u_dut (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode),
        .seed_we(seed_we), .seed_ch(seed_ch), .seed_data(seed_data),
        .rnd_ready(rnd_ready), .rnd_valid(rnd_valid), .rnd_data(rnd_data),
        .rnd_ch(rnd_ch), .zero_seed(zero_seed)
    );

    rgs_prng_bank #(.CHANNELS(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .en(en3), .mode(mode3),
        .seed_we(seed_we3), .seed_ch(seed_ch3), .seed_data(seed_data3),
        .rnd_ready(rnd_ready3), .rnd_valid(rnd_valid3), .rnd_data(rnd_data3),
        .rnd_ch(rnd_ch3), .zero_seed(zero_seed3)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        en = 0; mode = 2'b00; seed_we = 0; seed_ch = '0; seed_data = '0; rnd_ready = 0;
        en3 = 0; mode3 = 2'b00; seed_we3 = 0; seed_ch3 = '0; seed_data3 = '0; rnd_ready3 = 0;
    endtask

    // Called just after a tick, so release lands on the falling edge.
    task automatic do_reset;
        idle();
        rst_n = 0;
        #4;
        rst_n = 1;
    endtask

    task automatic test_reset;
        idle();
        #2;
        tests_run++;
        if ({rnd_valid, rnd_data, rnd_ch, zero_seed} !== 19'd0) begin
            tests_failed++;
            $display("FAIL reset_async: got v=%b d=%h c=%0d z=%b, want all zero",
                     rnd_valid, rnd_data, rnd_ch, zero_seed);
        end
        en = 1; mode = 2'b01; rnd_ready = 1;
        tick();
        tests_run++;
        if ({rnd_valid, rnd_data, rnd_ch, zero_seed} !== 19'd0) begin
            tests_failed++;
            $display("FAIL reset_held_clocked: got v=%b d=%h c=%0d z=%b, want all zero",
                     rnd_valid, rnd_data, rnd_ch, zero_seed);
        end
        tests_run++;
        if ({rnd_valid3, rnd_data3, rnd_ch3, zero_seed3} !== 20'd0) begin
            tests_failed++;
            $display("FAIL reset_dut3: got v=%b d=%h c=%0d z=%b, want all zero",
                     rnd_valid3, rnd_data3, rnd_ch3, zero_seed3);
        end
        $display("[TB] reset: v=%b d=%h c=%0d", rnd_valid, rnd_data, rnd_ch);
        do_reset();
    endtask

    task automatic test_on_demand;
        logic [15:0] exp_d [4];
        logic        exp_c [4];
        exp_d = '{16'hACE1, 16'hACE2, 16'hE270, 16'h5671};
        exp_c = '{1'b0, 1'b1, 1'b0, 1'b1};
        do_reset();
        en = 1; mode = 2'b10; rnd_ready = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            $display("[TB] on_demand word %0d: v=%b d=%h c=%0d", i, rnd_valid, rnd_data, rnd_ch);
            tests_run++;
            if (rnd_valid !== 1'b1 || rnd_data !== exp_d[i] || rnd_ch !== exp_c[i]) begin
                tests_failed++;
                $display("FAIL on_demand_%0d: got v=%b d=%h c=%0d, want v=1 d=%h c=%0d",
                         i, rnd_valid, rnd_data, rnd_ch, exp_d[i], exp_c[i]);
            end
        end
        mode = 2'b00;
        tick();
        tests_run++;
        if (rnd_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL consume_clears_valid: got v=%b, want 0", rnd_valid);
        end
    endtask

    task automatic test_backpressure;
        do_reset();
        en = 1; mode = 2'b10; rnd_ready = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            $display("[TB] backpressure hold %0d: v=%b d=%h c=%0d", i, rnd_valid, rnd_data, rnd_ch);
            tests_run++;
            if (rnd_valid !== 1'b1 || rnd_data !== 16'hACE1 || rnd_ch !== 1'b0) begin
                tests_failed++;
                $display("FAIL backpressure_hold_%0d: got v=%b d=%h c=%0d, want v=1 d=ace1 c=0",
                         i, rnd_valid, rnd_data, rnd_ch);
            end
        end
        rnd_ready = 1;
        tick();
        $display("[TB] backpressure next: v=%b d=%h c=%0d", rnd_valid, rnd_data, rnd_ch);
        tests_run++;
        if (rnd_valid !== 1'b1 || rnd_data !== 16'hACE2 || rnd_ch !== 1'b1) begin
            tests_failed++;
            $display("FAIL backpressure_next: got v=%b d=%h c=%0d, want v=1 d=ace2 c=1",
                     rnd_valid, rnd_data, rnd_ch);
        end
    endtask

    task automatic test_free_run;
        do_reset();
        en = 1; mode = 2'b01; rnd_ready = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            tests_run++;
            if (rnd_valid !== 1'b1 || rnd_data !== 16'hACE1 || rnd_ch !== 1'b0) begin
                tests_failed++;
                $display("FAIL free_run_hold_%0d: got v=%b d=%h c=%0d, want v=1 d=ace1 c=0",
                         i, rnd_valid, rnd_data, rnd_ch);
            end
        end
        rnd_ready = 1;
        tick();
        $display("[TB] free_run next: v=%b d=%h c=%0d", rnd_valid, rnd_data, rnd_ch);
        // ch1 after four steps: ACE2 -> 5671 -> 9F38 -> 4F9C -> 27CE
        tests_run++;
        if (rnd_valid !== 1'b1 || rnd_data !== 16'h27CE || rnd_ch !== 1'b1) begin
            tests_failed++;
            $display("FAIL free_run_next: got v=%b d=%h c=%0d, want v=1 d=27ce c=1",
                     rnd_valid, rnd_data, rnd_ch);
        end
    endtask

    task automatic test_seed;
        logic [15:0] exp_d [3];
        logic        exp_c [3];
        exp_d = '{16'h1234, 16'hACE1, 16'h091A};
        exp_c = '{1'b1, 1'b0, 1'b1};
        do_reset();
        en = 1; mode = 2'b10; rnd_ready = 1;
        tick();
        en = 0; mode = 2'b00; seed_we = 1; seed_ch = 1'b0; seed_data = 16'h0000;
        tick();
        $display("[TB] seed zero write: z=%b", zero_seed);
        tests_run++;
        if (zero_seed !== 1'b1) begin
            tests_failed++;
            $display("FAIL zero_seed_pulse: got %b, want 1", zero_seed);
        end
        seed_ch = 1'b1; seed_data = 16'h1234;
        tick();
        tests_run++;
        if (zero_seed !== 1'b0) begin
            tests_failed++;
            $display("FAIL zero_seed_one_cycle: got %b, want 0", zero_seed);
        end
        seed_we = 0; en = 1; mode = 2'b10;
        for (int i = 0; i < 3; i++) begin
            // Second word shares its cycle with a seed write to the same channel.
            if (i == 1) begin
                seed_we = 1; seed_ch = 1'b0; seed_data = 16'h5555;
            end else begin
                seed_we = 0;
            end
            tick();
            $display("[TB] seed word %0d: v=%b d=%h c=%0d", i, rnd_valid, rnd_data, rnd_ch);
            tests_run++;
            if (rnd_valid !== 1'b1 || rnd_data !== exp_d[i] || rnd_ch !== exp_c[i]) begin
                tests_failed++;
                $display("FAIL seed_word_%0d: got v=%b d=%h c=%0d, want v=1 d=%h c=%0d",
                         i, rnd_valid, rnd_data, rnd_ch, exp_d[i], exp_c[i]);
            end
        end
        seed_we = 0;
        tick();
        tests_run++;
        if (rnd_data !== 16'h5555 || rnd_ch !== 1'b0) begin
            tests_failed++;
            $display("FAIL seed_over_step: got d=%h c=%0d, want d=5555 c=0", rnd_data, rnd_ch);
        end
    endtask

    task automatic test_ignored_seed;
        logic [15:0] exp_d [4];
        logic [1:0]  exp_c [4];
        exp_d = '{16'hACE1, 16'hACE2, 16'hACE3, 16'hE270};
        exp_c = '{2'd0, 2'd1, 2'd2, 2'd0};
        do_reset();
        seed_we3 = 1; seed_ch3 = 2'd3; seed_data3 = 16'h0000;
        tick();
        tests_run++;
        if (zero_seed3 !== 1'b0) begin
            tests_failed++;
            $display("FAIL ignored_seed_pulse: got %b, want 0", zero_seed3);
        end
        seed_we3 = 0; en3 = 1; mode3 = 2'b10; rnd_ready3 = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            $display("[TB] dut3 word %0d: v=%b d=%h c=%0d", i, rnd_valid3, rnd_data3, rnd_ch3);
            tests_run++;
            if (rnd_valid3 !== 1'b1 || rnd_data3 !== exp_d[i] || rnd_ch3 !== exp_c[i]) begin
                tests_failed++;
                $display("FAIL dut3_word_%0d: got v=%b d=%h c=%0d, want v=1 d=%h c=%0d",
                         i, rnd_valid3, rnd_data3, rnd_ch3, exp_d[i], exp_c[i]);
            end
        end
    endtask

    task automatic test_reset_midtransfer;
        do_reset();
        en = 1; mode = 2'b10; rnd_ready = 0;
        tick();
        #1;
        rst_n = 0;
        #1;
        $display("[TB] mid-transfer reset: v=%b d=%h", rnd_valid, rnd_data);
        tests_run++;
        if (rnd_valid !== 1'b0 || rnd_data !== 16'h0000) begin
            tests_failed++;
            $display("FAIL reset_midtransfer: got v=%b d=%h, want v=0 d=0000", rnd_valid, rnd_data);
        end
        #1;
        rst_n = 1;
        rnd_ready = 1;
        tick();
        tests_run++;
        if (rnd_valid !== 1'b1 || rnd_data !== 16'hACE1 || rnd_ch !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_restart: got v=%b d=%h c=%0d, want v=1 d=ace1 c=0",
                     rnd_valid, rnd_data, rnd_ch);
        end
    endtask

    task automatic test_halt;
        do_reset();
        en = 1; mode = 2'b10; rnd_ready = 1;
        tick();
        tick();
        rnd_ready = 0; en = 0;
        for (int i = 0; i < 10; i++) begin
            if (i == 5) begin
                en = 1; mode = 2'b00;
            end
            tick();
            tests_run++;
            if (rnd_valid !== 1'b1 || rnd_data !== 16'hACE2 || rnd_ch !== 1'b1) begin
                tests_failed++;
                $display("FAIL halt_hold_%0d: got v=%b d=%h c=%0d, want v=1 d=ace2 c=1",
                         i, rnd_valid, rnd_data, rnd_ch);
            end
        end
        mode = 2'b10; rnd_ready = 1;
        tick();
        tests_run++;
        if (rnd_data !== 16'hE270 || rnd_ch !== 1'b0) begin
            tests_failed++;
            $display("FAIL halt_resume_0: got d=%h c=%0d, want d=e270 c=0", rnd_data, rnd_ch);
        end
        tick();
        $display("[TB] halt resume: d=%h c=%0d", rnd_data, rnd_ch);
        tests_run++;
        if (rnd_data !== 16'h5671 || rnd_ch !== 1'b1) begin
            tests_failed++;
            $display("FAIL halt_resume_1: got d=%h c=%0d, want d=5671 c=1", rnd_data, rnd_ch);
        end

        // Free-run: en=0 and mode=00 must both stop stepping.
        do_reset();
        en = 1; mode = 2'b01; rnd_ready = 0;
        tick();
        en = 0;
        for (int i = 0; i < 10; i++) begin
            if (i == 5) begin
                en = 1; mode = 2'b00;
            end
            tick();
        end
        mode = 2'b01; rnd_ready = 1;
        tick();
        $display("[TB] free_run halt resume: v=%b d=%h c=%0d", rnd_valid, rnd_data, rnd_ch);
        tests_run++;
        if (rnd_valid !== 1'b1 || rnd_data !== 16'h5671 || rnd_ch !== 1'b1) begin
            tests_failed++;
            $display("FAIL free_run_halt: got v=%b d=%h c=%0d, want v=1 d=5671 c=1",
                     rnd_valid, rnd_data, rnd_ch);
        end
    endtask

    initial begin
        test_reset();
        test_on_demand();
        test_backpressure();
        test_free_run();
        test_seed();
        test_ignored_seed();
        test_reset_midtransfer();
        test_halt();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
